// File: rtl/dmem_access_unit_pkg.sv
// dmem_access_unit_pkg: op codes, memory write-enable constants, FSM states and op decode helpers.
package dmem_access_unit_pkg;
    localparam int WORD_W = 32;
    localparam logic MemLoad = 1'b0;
    localparam logic MemSave = 1'b1;
    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_e;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;
    function automatic logic is_load(op_e op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction
    function automatic logic misaligned(op_e op, logic [1:0] off);
        return (op inside {OP_LH, OP_LHU, OP_SH} && off[0]) || (op inside {OP_LW, OP_SW} && off != 2'b00);
    endfunction
endpackage

// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: MEM-stage request/response and data-memory word port of the access unit.
interface dmem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import dmem_access_unit_pkg::*;
    logic              req;
    op_e               op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              mem_wena;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    modport master (
        output req, op, addr, wdata, mem_rdata,
        input  busy, done, err, rdata, mem_wena, mem_addr, mem_wdata
    );
    modport slave (
        input  req, op, addr, wdata, mem_rdata,
        output busy, done, err, rdata, mem_wena, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_access_unit_lane_align.sv
// dmem_lane_align: little-endian lane extract/extend for loads and lane merge for sub-word stores.
module dmem_lane_align
    import dmem_access_unit_pkg::*;
(
    input  op_e               i_op,
    input  logic [1:0]        i_off,
    input  logic [WORD_W-1:0] i_word,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_load,
    output logic [WORD_W-1:0] o_merge
);
    logic [4:0]        w_bsh;
    logic [4:0]        w_hsh;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [WORD_W-1:0] w_bmask;
    logic [WORD_W-1:0] w_hmask;
    assign w_bsh   = {i_off, 3'b000};
    assign w_hsh   = {i_off[1], 4'b0000};
    assign w_byte  = i_word[w_bsh +: 8];
    assign w_half  = i_word[w_hsh +: 16];
    assign w_bmask = 32'h0000_00FF << w_bsh;
    assign w_hmask = 32'h0000_FFFF << w_hsh;
    assign o_load  = i_op == OP_LB  ? {{24{w_byte[7]}}, w_byte} :
                     i_op == OP_LBU ? {24'b0, w_byte} :
                     i_op == OP_LH  ? {{16{w_half[15]}}, w_half} :
                     i_op == OP_LHU ? {16'b0, w_half} : i_word;
    assign o_merge = i_op == OP_SB ? (i_word & ~w_bmask) | ({24'b0, i_wdata[7:0]} << w_bsh) :
                     i_op == OP_SH ? (i_word & ~w_hmask) | ({16'b0, i_wdata[15:0]} << w_hsh) : i_wdata;
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store initiator; sub-word stores are read-modify-write on the word port.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic               clk,
    input logic               rst_n,
    dmem_access_unit_if.slave bus
);
    state_e            r_state;
    op_e               r_op;
    logic [1:0]        r_off;
    logic [DATA_W-1:0] r_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic              r_wena;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merge;
    dmem_lane_align u_align (
        .i_op    (r_op),
        .i_off   (r_off),
        .i_word  (bus.mem_rdata),
        .i_wdata (r_wdata),
        .o_load  (w_load),
        .o_merge (w_merge)
    );
    // the memory commits on negedge, so a reset asserted mid-WRITE must mask the enable at once
    assign bus.mem_wena  = rst_n ? r_wena : MemLoad;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.rdata     = r_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_LB;
            r_off       <= 2'b00;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_wena      <= MemLoad;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: if (bus.req) begin
                    r_op       <= bus.op;
                    r_off      <= bus.addr[1:0];
                    r_wdata    <= bus.wdata;
                    r_mem_addr <= {bus.addr[ADDR_W-1:2], 2'b00};
                    r_busy     <= 1'b1;
                    if (misaligned(bus.op, bus.addr[1:0])) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else if (bus.op == OP_SW) begin
                        r_state     <= ST_WRITE;
                        r_wena      <= MemSave;
                        r_mem_wdata <= bus.wdata;
                    end else begin
                        r_state <= ST_READ;
                    end
                end
                ST_READ: if (is_load(r_op)) begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                    r_rdata <= w_load;
                end else begin
                    r_state     <= ST_WRITE;
                    r_wena      <= MemSave;
                    r_mem_wdata <= w_merge;
                end
                ST_WRITE: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                    r_wena  <= MemLoad;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed and random load/store traffic checked against a byte-array memory model.
module tb_dmem_access_unit;
    import dmem_access_unit_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_err = 0;
    logic [31:0] mem [0:255];
    logic [7:0]  ref_b [0:1023];
    logic [31:0] exp_rdata = 32'h0;
    dmem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    dmem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
    always @(negedge clk) if (bus.mem_wena == MemSave) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic set_word(input int a, input logic [31:0] v);
        mem[a / 4] = v;
        for (int i = 0; i < 4; i++) ref_b[a + i] = v[8 * i +: 8];
    endtask
    function automatic logic [31:0] ref_word(input int a);
        return {ref_b[a + 3], ref_b[a + 2], ref_b[a + 1], ref_b[a]};
    endfunction
    function automatic int op_size(input op_e op);
        return (op == OP_LW || op == OP_SW) ? 4 : (op inside {OP_LH, OP_LHU, OP_SH}) ? 2 : 1;
    endfunction
    function automatic logic [31:0] ref_load(input op_e op, input int a);
        logic [31:0] v = 0;
        int sz = op_size(op);
        for (int i = 0; i < sz; i++) v |= 32'(ref_b[a + i]) << (8 * i);
        if ((op == OP_LB || op == OP_LH) && v[8 * sz - 1]) v |= 32'hFFFF_FFFF << (8 * sz);
        return v;
    endfunction
    task automatic run(input op_e op, input int a, input logic [31:0] wd);
        int sz = op_size(op);
        bit bad = (a % sz) != 0;
        bit ld = op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
        int lat = 0;
        int saves = 0;
        logic [31:0] got_w = 0;
        logic [31:0] got_a = 0;
        @(negedge clk);
        bus.req = 1'b1;
        bus.op = op;
        bus.addr = a;
        bus.wdata = wd;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.mem_wena == MemSave) begin
                saves++;
                got_w = bus.mem_wdata;
                got_a = bus.mem_addr;
            end
        end while (!bus.done && lat < 8);
        bus.req = 1'b0;
        chk($sformatf("latency op%0d @%h", op, a), lat, bad ? 1 : (op == OP_SB || op == OP_SH) ? 3 : 2);
        chk("busy_at_done", bus.busy, 1);
        chk($sformatf("err op%0d @%h", op, a), bus.err, bad);
        if (!bad && !ld) for (int i = 0; i < sz; i++) ref_b[a + i] = wd[8 * i +: 8];
        if (!bad && ld) exp_rdata = ref_load(op, a);
        chk($sformatf("rdata op%0d @%h", op, a), bus.rdata, exp_rdata);
        chk("save_cycles", saves, (!bad && !ld) ? 1 : 0);
        if (!bad && !ld) begin
            chk("wr_addr", got_a, a & ~3);
            chk("wr_data", got_w, ref_word(a & ~3));
        end
        @(posedge clk);
        #1;
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", bus.done, 0);
    endtask
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_rdata"}, bus.rdata, 0);
        chk({tag, "_wena"}, bus.mem_wena, MemLoad);
        chk({tag, "_maddr"}, bus.mem_addr, 0);
        chk({tag, "_mwdata"}, bus.mem_wdata, 0);
    endtask
    initial begin
        int dones, idles;
        bus.req = 1'b0;
        bus.op = OP_LB;
        bus.addr = 0;
        bus.wdata = 0;
        for (int w = 0; w < 256; w++) set_word(w * 4, $urandom);
        set_word(32'h20, 32'h8070_F0FF);
        set_word(32'h30, 32'h1122_3344);
        set_word(32'h40, 32'h5555_5555);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        run(OP_SW, 32'h10, 32'hDEAD_BEEF);
        run(OP_LW, 32'h10, 0);
        chk("lw_deadbeef", bus.rdata, 32'hDEAD_BEEF);
        run(OP_LB, 32'h20, 0);
        chk("lb_20", bus.rdata, 32'hFFFF_FFFF);
        run(OP_LBU, 32'h21, 0);
        chk("lbu_21", bus.rdata, 32'h0000_00F0);
        run(OP_LH, 32'h22, 0);
        chk("lh_22", bus.rdata, 32'hFFFF_8070);
        run(OP_LHU, 32'h22, 0);
        chk("lhu_22", bus.rdata, 32'h0000_8070);
        run(OP_SB, 32'h31, 32'h0000_00AA);
        run(OP_LW, 32'h30, 0);
        chk("sb_merge", bus.rdata, 32'h1122_AA44);
        run(OP_SH, 32'h33, 32'h1234_5678);
        run(OP_LW, 32'h22, 0);
        chk("err_rdata_hold", bus.rdata, 32'h1122_AA44);
        // reset asserted during the WRITE cycle of a halfword store
        @(negedge clk);
        bus.req = 1'b1;
        bus.op = OP_SH;
        bus.addr = 32'h40;
        bus.wdata = 32'h0000_ABCD;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pre_wena", bus.mem_wena, MemSave);
        rst_n = 1'b0;
        #1;
        chk("rst_wena_forced", bus.mem_wena, MemLoad);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        chk_reset_vals("midrst");
        exp_rdata = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run(OP_LW, 32'h40, 0);
        chk("rst_no_write", bus.rdata, 32'h5555_5555);
        // req held through DONE: each accepted LW needs a fresh IDLE sample
        @(negedge clk);
        bus.req = 1'b1;
        bus.op = OP_LW;
        bus.addr = 32'h10;
        dones = 0;
        idles = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            dones += int'(bus.done);
            idles += int'(!bus.busy);
        end
        bus.req = 1'b0;
        chk("b2b_dones", dones, 3);
        chk("b2b_idles", idles, 2);
        exp_rdata = ref_load(OP_LW, 32'h10);
        chk("b2b_rdata", bus.rdata, exp_rdata);
        @(posedge clk);
        for (int n = 0; n < 300; n++) begin
            op_e op = op_e'($urandom_range(0, 7));
            int a = $urandom_range(0, 1023);
            if ($urandom_range(0, 3) != 0) a = a & ~(op_size(op) - 1);
            run(op, a, $urandom);
        end
        for (int w = 0; w < 256; w++) chk($sformatf("mem[%0d]", w), mem[w], ref_word(w * 4));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
